id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage 64-bit CPU; sits between the IF/ID pipeline register and the ID/EX pipeline register.
- Holds the 8x64 register file and decodes the 32-bit instruction into operands, a sign-extended immediate and EX/MEM/WB control bundles.
- Detects load-use hazards, stalls IF with a one-cycle bubble, and accepts the write-back port from WB.

Parameters:
- DATA_W, 64, register and operand width
- NREG_LOG2, 3, register index width (8 registers)
- PC_W, 9, instruction-address / branch-target width

Ports:
- clk  input  1  stage clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears register file
- instr  input  32  instruction from IF/ID register
- flush  input  1  branch-taken squash from EX; forces bubble
- wb_we  input  1  write-back enable
- wb_wreg  input  3  write-back destination index
- wb_data  input  64  write-back data
- ex_mem_read  input  1  instruction now in EX is a load
- ex_wreg  input  3  destination of instruction now in EX
- ID_reg_data1  output  64  rs1 operand
- ID_reg_data2  output  64  rs2 operand
- ID_imm  output  64  sign-extended instr[15:0]
- ID_Wreg  output  3  destination index rd
- ID_addr_ins  output  9  branch target instr[8:0]
- ID_EX_CTRL  output  5  {alu_src_imm, alu_op[3:0]}
- ID_MEM_CTRL  output  1  memory write (store)
- ID_WB_CTRL  output  2  {reg_write, mem_to_reg}
- stall  output  1  hold PC and IF/ID register this cycle

Behaviour:
- Instruction fields: opcode = instr[31:28], rd = [27:25], rs1 = [24:22], rs2 = [21:19], imm16 = [15:0], target = [8:0].
- Register file: 8 x 64, written on posedge clk when wb_we=1 and wb_wreg!=0. R0 always reads 0 and writes to it are dropped.
- Async reset clears all 8 registers immediately, independent of clk. Reset mid-write: reset wins and the register stays 0.
- Read bypass: if wb_we=1, wb_wreg==rsN and rsN!=0, the operand is wb_data in the same cycle (write-then-read semantics). Otherwise the operand is the stored value. Reads are combinational.
- ID_imm = {{48{imm16[15]}}, imm16}. ID_addr_ins = instr[8:0]. ID_Wreg = rd.
- Decode table, given as opcode: alu_op, alu_src_imm, mem_wr, reg_write, mem_to_reg:
  - 0 NOP: 0, 0, 0, 0, 0
  - 1 ADD: 1, 0, 0, 1, 0
  - 2 SUB: 2, 0, 0, 1, 0
  - 3 AND: 3, 0, 0, 1, 0
  - 4 OR: 4, 0, 0, 1, 0
  - 5 XOR: 5, 0, 0, 1, 0
  - 6 ADDI: 1, 1, 0, 1, 0
  - 7 LD: 1, 1, 0, 1, 1
  - 8 ST: 1, 1, 1, 0, 0
  - 9 BEQ: 2, 0, 0, 0, 0
  - 10 SHL: 6, 0, 0, 1, 0
  - 11 SHR: 7, 0, 0, 1, 0
  - 12-15: decoded as NOP.
- Load-use hazard: stall=1 when ex_mem_read=1, ex_wreg!=0, and (ex_wreg==rs1, or ex_wreg==rs2 for opcodes that read rs2: 1-5, 8, 9, 10, 11).
- On stall: ID_EX_CTRL, ID_MEM_CTRL and ID_WB_CTRL = 0 (bubble). Data fields pass through unchanged.
- The same instr is re-presented next cycle and decodes normally once EX holds the bubble. Stall lasts exactly one cycle per hazard.
- flush=1 forces the bubble on the control outputs and forces stall=0. Flush has priority over stall.
- While reset is asserted: control outputs = 0, stall = 0, operands read 0.
- Latency: all outputs are combinational from the inputs and the register-file state; the ID/EX register provides the pipeline cut.

Test Plan:
- Reset, then read R1..R7 with ADD rs1=r3, rs2=r5 -> ID_reg_data1 = ID_reg_data2 = 0 and ID_WB_CTRL = 2'b10.
- WB write r2 = 64'hDEAD_BEEF_0000_0001 while decoding ADD rs1=r2 in the same cycle -> ID_reg_data1 = that value (bypass). Next cycle, with wb_we=0, the same value is read from storage.
- WB write r0 = 5, then read r0 -> 0 in both the bypass cycle and the following cycle.
- ADDI imm16 = 16'hFFF0 -> ID_imm = 64'hFFFF_FFFF_FFFF_FFF0 and ID_EX_CTRL = 5'b1_0001.
- ex_mem_read=1, ex_wreg=3, decoding SUB rs2=r3 -> stall=1 and controls = 0. Next cycle, with ex_mem_read=0 -> stall=0 and ID_EX_CTRL = 5'b0_0010.
- Same hazard with flush=1 -> stall=0 and controls = 0. Assert reset mid-cycle after writing r4 = 7 -> r4 reads 0 immediately, without a clock edge.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage 64-bit CPU.
//
// Purpose:
//   Holds the 8 x DATA_W register file and splits the 32-bit instruction
//   into its fields. It produces the two source operands, with a bypass from
//   the write-back port, a sign-extended immediate, the branch target and the
//   EX/MEM/WB control bundles. It also detects load-use hazards and requests
//   a one-cycle stall of IF.
//
// Ports:
//   clk, reset      - stage clock; asynchronous active-high reset that
//                     clears the register file
//   instr           - instruction word from the IF/ID register
//   flush           - branch-taken squash from EX; forces a bubble
//   wb_we/wb_wreg/wb_data - write-back port from WB
//   ex_mem_read/ex_wreg   - load-in-EX information used for hazard detection
//   ID_reg_data1/2  - rs1 / rs2 operands
//   ID_imm          - sign-extended instr[15:0]
//   ID_Wreg         - destination register index (rd)
//   ID_addr_ins     - branch target instr[8:0]
//   ID_EX_CTRL      - {alu_src_imm, alu_op[3:0]}
//   ID_MEM_CTRL     - memory write (store)
//   ID_WB_CTRL      - {reg_write, mem_to_reg}
//   stall           - hold the PC and the IF/ID register this cycle
module id_stage #(
  parameter int DATA_W    = 64,
  parameter int NREG_LOG2 = 3,
  parameter int PC_W      = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [NREG_LOG2-1:0] wb_wreg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 ex_mem_read,
  input  logic [NREG_LOG2-1:0] ex_wreg,
  output logic [DATA_W-1:0]    ID_reg_data1,
  output logic [DATA_W-1:0]    ID_reg_data2,
  output logic [DATA_W-1:0]    ID_imm,
  output logic [NREG_LOG2-1:0] ID_Wreg,
  output logic [PC_W-1:0]      ID_addr_ins,
  output logic [4:0]           ID_EX_CTRL,
  output logic                 ID_MEM_CTRL,
  output logic [1:0]           ID_WB_CTRL,
  output logic                 stall
);

  localparam int NREG = 1 << NREG_LOG2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_BEQ  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11
  } opcode_e;

  logic [3:0]           opcode;
  logic [NREG_LOG2-1:0] rd, rs1, rs2;
  logic [15:0]          imm16;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic [3:0] alu_op;
  logic       alu_src_imm, mem_wr, reg_write, mem_to_reg, reads_rs2;
  logic       hazard, bubble;

  // instr[18:16] is not part of any field.
  logic unused_instr_bits;

  assign opcode = instr[31:28];
  assign rd     = instr[27:25];
  assign rs1    = instr[24:22];
  assign rs2    = instr[21:19];
  assign imm16  = instr[15:0];
  assign unused_instr_bits = ^instr[18:16];

  // Writes to R0 are dropped, so rf_q[0] never leaves zero.
  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_wreg != '0)) begin
      rf_d[wb_wreg] = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Operand read with write-then-read bypass from WB. Reset forces zero so
  // that nothing in flight leaks through while the file is being cleared.
  always_comb begin
    ID_reg_data1 = '0;
    ID_reg_data2 = '0;
    if (!reset) begin
      if (rs1 != '0) begin
        ID_reg_data1 = (wb_we && (wb_wreg == rs1)) ? wb_data : rf_q[rs1];
      end
      if (rs2 != '0) begin
        ID_reg_data2 = (wb_we && (wb_wreg == rs2)) ? wb_data : rf_q[rs2];
      end
    end
  end

  assign ID_imm      = {{(DATA_W-16){imm16[15]}}, imm16};
  assign ID_Wreg     = rd;
  assign ID_addr_ins = instr[PC_W-1:0];

  // Opcodes 12-15 fall into the default and decode as NOP.
  always_comb begin
    alu_op      = 4'd0;
    alu_src_imm = 1'b0;
    mem_wr      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reads_rs2   = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_op = 4'd1; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_SUB:  begin alu_op = 4'd2; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_AND:  begin alu_op = 4'd3; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_OR:   begin alu_op = 4'd4; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_XOR:  begin alu_op = 4'd5; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_ADDI: begin alu_op = 4'd1; alu_src_imm = 1'b1; reg_write = 1'b1; end
      OP_LD: begin
        alu_op      = 4'd1;
        alu_src_imm = 1'b1;
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OP_ST: begin
        alu_op      = 4'd1;
        alu_src_imm = 1'b1;
        mem_wr      = 1'b1;
        reads_rs2   = 1'b1;
      end
      OP_BEQ:  begin alu_op = 4'd2; reads_rs2 = 1'b1; end
      OP_SHL:  begin alu_op = 4'd6; reg_write = 1'b1; reads_rs2 = 1'b1; end
      OP_SHR:  begin alu_op = 4'd7; reg_write = 1'b1; reads_rs2 = 1'b1; end
      default: begin end
    endcase
  end

  // A load in EX whose destination this instruction reads. rs1 is compared
  // for every opcode; rs2 only for opcodes that actually use it.
  assign hazard = ex_mem_read && (ex_wreg != '0) &&
                  ((ex_wreg == rs1) || (reads_rs2 && (ex_wreg == rs2)));

  // Flush outranks stall: a squashed instruction must not hold the PC.
  assign stall  = hazard && !flush && !reset;
  assign bubble = hazard || flush || reset;

  always_comb begin
    ID_EX_CTRL  = '0;
    ID_MEM_CTRL = 1'b0;
    ID_WB_CTRL  = '0;
    if (!bubble) begin
      ID_EX_CTRL  = {alu_src_imm, alu_op};
      ID_MEM_CTRL = mem_wr;
      ID_WB_CTRL  = {reg_write, mem_to_reg};
    end
  end

endmodule
